bids_ctrl_n: RTL
================

# bids_ctrl_n

Parametrised N-bidder auction controller, the next generation of the three-bidder BIDS22 controller. A control port loads balances, mask, bid cost and lockout timer and locks the block with a key. Bidders then place, retract and raise bids during a round. At round end the block settles balances and reports the winner and the maximum bid. It sits between the host control interface and the bidder agents.

## Interface
- NUM_BIDDERS, 3, number of bidder channels (2..16)
- BID_W, 16, bid amount width
- BAL_W, 32, balance, total and maxBid width (≥ BID_W+1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- bid  in  NUM_BIDDERS  bid request per bidder
- retract  in  NUM_BIDDERS  retract request per bidder
- bidAmt  in  NUM_BIDDERS*BID_W  amount per bidder; bidder i uses [i*BID_W +: BID_W]
- C_data  in  32  control data
- C_op  in  4  control opcode
- C_start  in  1  round active while high
- ack  out  NUM_BIDDERS  accepted bid, one pulse
- bidErr  out  2*NUM_BIDDERS  per-bidder error: 00 ok, 01 round inactive, 10 insufficient funds, 11 invalid request
- balance  out  NUM_BIDDERS*BAL_W  committed balance per bidder
- win  out  NUM_BIDDERS  one-hot winner, valid while roundOver=1
- ready  out  1  control port accepting operations
- err  out  3  000 none, 001 bad key, 010 already unlocked, 011 C_start while unlocked, 100 invalid op
- roundOver  out  1  settlement results valid
- maxBid  out  BAL_W  winning total

## Operation
- Opcodes: 0 NoOp, 1 Unlock, 2 Lock (key←C_data), 3 Select (sel←C_data), 4 Load (value[sel]←C_data[BAL_W-1:0]), 5 SetMask (mask←C_data[NUM_BIDDERS-1:0]), 6 SetTimer (timer←C_data[15:0]), 7 BidCharge (cost←C_data[BAL_W-1:0]). Opcodes 8–15 → err 100.
- Register defaults after reset: value 0, mask all ones, timer 15, key 0, cost 1, sel 0.
- Opcodes 3–7 act only in UNLOCKED. Select with C_data ≥ NUM_BIDDERS → err 100, sel unchanged. Load takes value[sel] for the sel in force at the start of that cycle.
- States: UNLOCKED, LOCKED, LOCKOUT, ACTIVE, OVER. Reset enters UNLOCKED.
- UNLOCKED:
  - Lock → LOCKED.
  - Unlock → err 010.
  - C_start=1 → err 011; the op is not executed.
- LOCKED:
  - C_start=1 → ACTIVE; clears totals and charges.
  - Unlock with C_data==key → UNLOCKED.
  - Unlock with a mismatched key → err 001 (see Configuration).
  - NoOp → no error.
  - Any other op → err 100.
- ACTIVE: each bidder is processed independently every cycle.
  - bid&retract, or a request from a bidder whose mask bit is 0 → bidErr 11, no state change; bid&retract also sets err 100.
  - Available funds: avail = value − total − charges.
  - Bid accepted iff bidAmt + cost ≤ avail: total += bidAmt, charges += cost, ack=1. Otherwise bidErr 10.
  - Retract accepted iff bidAmt ≤ total and cost ≤ avail: total −= bidAmt, charges += cost. Otherwise bidErr 10.
  - C_start=0 → OVER. Settlement happens on that edge.
- Settlement:
  - The winner is the highest total; a tie goes to the lowest index. If all totals are 0 there is no winner, win=0 and maxBid=0.
  - Winner: value −= total + charges. Every other bidder: value −= charges.
- OVER:
  - roundOver=1; win and maxBid are held.
  - C_start=1 → ACTIVE (new round); roundOver, win and maxBid clear.
  - Unlock is handled as in LOCKED.
  - NoOp → stay in OVER.
  - Any other op → err 100, stay in OVER.
- bid or retract outside ACTIVE → bidErr 01.
- All arithmetic is unsigned BAL_W; bidAmt is zero-extended. The checks above guarantee no underflow.

## Timing
- All outputs are registered and reflect inputs sampled at the previous rising edge; latency is 1 cycle.
- Reset values: ack 0, bidErr 0, balance 0, win 0, ready 0, err 0, roundOver 0, maxBid 0.
- ready=1 from the first edge with reset_n high, except while in LOCKOUT.
- err, ack and bidErr are single-cycle responses and return to 0 unless re-triggered.
- balance = value, updated the cycle after settlement or Load.
- Asserting reset_n low mid-round aborts the round. All registers return to their defaults and no settlement is applied.

## Configuration
- BIDS_LOCKOUT_EN defined:
  - A bad-key Unlock enters LOCKOUT for `timer` cycles with ready=0; C_op and C_start are ignored.
  - The block then returns to the state it came from (LOCKED or OVER).
  - timer=0 → return on the next cycle.
- BIDS_LOCKOUT_EN undefined: a bad key gives err 001 and the state is unchanged. The LOCKOUT state is removed, and timer is still writable but unused.

## Test plan
- Reset, Select 1, Load 100, Lock key 5, Unlock 5 → balance[1]=100, err 000, state UNLOCKED.
- With lockout: Lock key 5, Unlock 6 → err 001, ready=0 for 15 cycles, then ready=1 and still LOCKED.
- N=3, values 100/100/100, cost 1; round with bids 30/50/50, then C_start=0 → win=010, maxBid 50, balances 99/49/99.
- Value 10, cost 1, bid 10 → bidErr 10, ack 0; then bid 9 → ack 1.
- Mask 101, bidder 1 bids → bidErr 11. Bidder 0 bid&retract → bidErr 11, err 100.
- Bid 40 then retract 60 → bidErr 10, total stays 40; C_start=1 while UNLOCKED → err 011.

Source files
------------

// File: rtl/bids_ctrl_n.sv
// bids_ctrl_n: N-bidder auction controller.
// The host control port loads balances, mask, bid cost and lockout timer, then locks the
// block with a key. Bidders bid, retract and raise during a round. At round end the block
// settles balances and reports the one-hot winner and the winning total.
// Optional feature macro: BIDS_LOCKOUT_EN (a bad-key Unlock locks the control port out
// for `timer` cycles). Without it a bad key only reports an error.
module bids_ctrl_n #(
    parameter int NUM_BIDDERS = 3,
    parameter int BID_W       = 16,
    parameter int BAL_W       = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_BIDDERS-1:0]       bid,
    input  logic [NUM_BIDDERS-1:0]       retract,
    input  logic [NUM_BIDDERS*BID_W-1:0] bidAmt,
    input  logic [31:0]                  C_data,
    input  logic [3:0]                   C_op,
    input  logic                         C_start,
    output logic [NUM_BIDDERS-1:0]       ack,
    output logic [2*NUM_BIDDERS-1:0]     bidErr,
    output logic [NUM_BIDDERS*BAL_W-1:0] balance,
    output logic [NUM_BIDDERS-1:0]       win,
    output logic                         ready,
    output logic [2:0]                   err,
    output logic                         roundOver,
    output logic [BAL_W-1:0]             maxBid
);
    localparam int SEL_W = $clog2(NUM_BIDDERS);

    localparam logic [3:0] OP_NOOP   = 4'd0;
    localparam logic [3:0] OP_UNLOCK = 4'd1;
    localparam logic [3:0] OP_LOCK   = 4'd2;
    localparam logic [3:0] OP_SELECT = 4'd3;
    localparam logic [3:0] OP_LOAD   = 4'd4;
    localparam logic [3:0] OP_MASK   = 4'd5;
    localparam logic [3:0] OP_TIMER  = 4'd6;
    localparam logic [3:0] OP_COST   = 4'd7;

    localparam logic [2:0] ERR_NONE  = 3'b000;
    localparam logic [2:0] ERR_KEY   = 3'b001;
    localparam logic [2:0] ERR_UNLK  = 3'b010;
    localparam logic [2:0] ERR_START = 3'b011;
    localparam logic [2:0] ERR_OP    = 3'b100;

`ifdef BIDS_LOCKOUT_EN
    typedef enum logic [2:0] {S_UNLOCKED = 3'd0, S_LOCKED = 3'd1, S_LOCKOUT = 3'd2,
                              S_ACTIVE = 3'd3, S_OVER = 3'd4} state_t;
`else
    typedef enum logic [2:0] {S_UNLOCKED = 3'd0, S_LOCKED = 3'd1,
                              S_ACTIVE = 3'd3, S_OVER = 3'd4} state_t;
`endif

    state_t                              state_q, state_d;
    logic [NUM_BIDDERS-1:0][BAL_W-1:0]   value_q, value_d;
    logic [NUM_BIDDERS-1:0][BAL_W-1:0]   total_q, total_d;
    logic [NUM_BIDDERS-1:0][BAL_W-1:0]   charge_q, charge_d;
    logic [NUM_BIDDERS-1:0]              mask_q, mask_d;
    logic [15:0]                         timer_q, timer_d;
    logic [31:0]                         key_q, key_d;
    logic [BAL_W-1:0]                    cost_q, cost_d;
    logic [SEL_W-1:0]                    sel_q, sel_d;
`ifdef BIDS_LOCKOUT_EN
    state_t                              ret_q, ret_d;
    logic [15:0]                         cnt_q, cnt_d;
`else
    // timer stays host-writable but has no consumer in this build
    logic                                unused_timer;
    assign unused_timer = ^timer_q;
`endif

    logic [NUM_BIDDERS-1:0]              ack_d, win_d;
    logic [2*NUM_BIDDERS-1:0]            bidErr_d;
    logic [2:0]                          err_d;
    logic                                ready_d, ro_d;
    logic [BAL_W-1:0]                    maxBid_d;

    logic [BAL_W-1:0]                    amt, avail, best_tot;
    logic [BAL_W:0]                      need;
    logic [SEL_W-1:0]                    best_idx;
    logic                                found;

    // Next-state, register-update and response logic for the whole controller
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        total_d  = total_q;
        charge_d = charge_q;
        mask_d   = mask_q;
        timer_d  = timer_q;
        key_d    = key_q;
        cost_d   = cost_q;
        sel_d    = sel_q;
`ifdef BIDS_LOCKOUT_EN
        ret_d    = ret_q;
        cnt_d    = cnt_q;
`endif
        ack_d    = '0;
        bidErr_d = '0;
        err_d    = ERR_NONE;
        win_d    = win;
        maxBid_d = maxBid;
        ro_d     = roundOver;
        amt      = '0;
        avail    = '0;
        need     = '0;
        best_tot = '0;
        best_idx = '0;
        found    = 1'b0;

        // Requests outside a running round are refused; ACTIVE overrides below
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (bid[i] | retract[i]) bidErr_d[2*i +: 2] = 2'b01;
        end

        case (state_q)
            S_UNLOCKED: begin
                if (C_start) begin
                    err_d = ERR_START;
                end else begin
                    case (C_op)
                        OP_NOOP:   ;
                        OP_UNLOCK: err_d = ERR_UNLK;
                        OP_LOCK: begin
                            key_d   = C_data;
                            state_d = S_LOCKED;
                        end
                        OP_SELECT: begin
                            if (C_data < 32'(NUM_BIDDERS)) sel_d = C_data[SEL_W-1:0];
                            else                           err_d = ERR_OP;
                        end
                        OP_LOAD:   value_d[sel_q] = BAL_W'(C_data);
                        OP_MASK:   mask_d  = C_data[NUM_BIDDERS-1:0];
                        OP_TIMER:  timer_d = C_data[15:0];
                        OP_COST:   cost_d  = BAL_W'(C_data);
                        default:   err_d   = ERR_OP;
                    endcase
                end
            end

            S_LOCKED, S_OVER: begin
                if (C_start) begin
                    state_d  = S_ACTIVE;
                    total_d  = '0;
                    charge_d = '0;
                    ro_d     = 1'b0;
                    win_d    = '0;
                    maxBid_d = '0;
                end else if (C_op == OP_NOOP) begin
                    state_d = state_q;
                end else if (C_op == OP_UNLOCK) begin
                    if (C_data == key_q) begin
                        // Leaving the round results behind: they no longer describe the block
                        state_d  = S_UNLOCKED;
                        ro_d     = 1'b0;
                        win_d    = '0;
                        maxBid_d = '0;
                    end else begin
                        err_d = ERR_KEY;
`ifdef BIDS_LOCKOUT_EN
                        ret_d   = state_q;
                        cnt_d   = timer_q;
                        state_d = S_LOCKOUT;
`endif
                    end
                end else begin
                    err_d = ERR_OP;
                end
            end

`ifdef BIDS_LOCKOUT_EN
            S_LOCKOUT: begin
                // Counter holds the remaining lockout cycles; 0 and 1 both mean "last one"
                if (cnt_q <= 16'd1) state_d = ret_q;
                else                cnt_d   = cnt_q - 16'd1;
            end
`endif

            S_ACTIVE: begin
                if (!C_start) begin
                    // Settle on the totals committed so far; strict '>' keeps the lowest
                    // index on ties and never elects a bidder whose total is zero
                    for (int i = 0; i < NUM_BIDDERS; i++) begin
                        if (total_q[i] > best_tot) begin
                            best_tot = total_q[i];
                            best_idx = SEL_W'(i);
                            found    = 1'b1;
                        end
                    end
                    win_d = '0;
                    if (found) win_d[best_idx] = 1'b1;
                    for (int i = 0; i < NUM_BIDDERS; i++) begin
                        value_d[i] = value_q[i] - charge_q[i] - (win_d[i] ? total_q[i] : '0);
                    end
                    maxBid_d = best_tot;
                    ro_d     = 1'b1;
                    state_d  = S_OVER;
                end else begin
                    for (int i = 0; i < NUM_BIDDERS; i++) begin
                        amt   = {{(BAL_W-BID_W){1'b0}}, bidAmt[i*BID_W +: BID_W]};
                        avail = value_q[i] - total_q[i] - charge_q[i];
                        need  = {1'b0, amt} + {1'b0, cost_q};
                        bidErr_d[2*i +: 2] = 2'b00;
                        if (bid[i] & retract[i]) begin
                            bidErr_d[2*i +: 2] = 2'b11;
                            err_d              = ERR_OP;
                        end else if ((bid[i] | retract[i]) & ~mask_q[i]) begin
                            bidErr_d[2*i +: 2] = 2'b11;
                        end else if (bid[i]) begin
                            if (need <= {1'b0, avail}) begin
                                total_d[i]  = total_q[i] + amt;
                                charge_d[i] = charge_q[i] + cost_q;
                                ack_d[i]    = 1'b1;
                            end else begin
                                bidErr_d[2*i +: 2] = 2'b10;
                            end
                        end else if (retract[i]) begin
                            if ((amt <= total_q[i]) && (cost_q <= avail)) begin
                                total_d[i]  = total_q[i] - amt;
                                charge_d[i] = charge_q[i] + cost_q;
                            end else begin
                                bidErr_d[2*i +: 2] = 2'b10;
                            end
                        end
                    end
                end
            end

            default: state_d = S_UNLOCKED;
        endcase

`ifdef BIDS_LOCKOUT_EN
        ready_d = (state_d != S_LOCKOUT);
`else
        ready_d = 1'b1;
`endif
    end

    // State and register file, with all outputs registered one cycle after their inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_UNLOCKED;
            value_q   <= '0;
            total_q   <= '0;
            charge_q  <= '0;
            mask_q    <= '1;
            timer_q   <= 16'd15;
            key_q     <= '0;
            cost_q    <= BAL_W'(1);
            sel_q     <= '0;
`ifdef BIDS_LOCKOUT_EN
            ret_q     <= S_LOCKED;
            cnt_q     <= '0;
`endif
            ack       <= '0;
            bidErr    <= '0;
            balance   <= '0;
            win       <= '0;
            ready     <= 1'b0;
            err       <= ERR_NONE;
            roundOver <= 1'b0;
            maxBid    <= '0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            total_q   <= total_d;
            charge_q  <= charge_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
            key_q     <= key_d;
            cost_q    <= cost_d;
            sel_q     <= sel_d;
`ifdef BIDS_LOCKOUT_EN
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
`endif
            ack       <= ack_d;
            bidErr    <= bidErr_d;
            balance   <= value_q;
            win       <= win_d;
            ready     <= ready_d;
            err       <= err_d;
            roundOver <= ro_d;
            maxBid    <= maxBid_d;
        end
    end
endmodule
